// File: rtl/memory_1r1w_resp.sv
// One-read/one-write memory with a fixed read latency, optional zero-fill after reset
// and a registered ready flag. Reads return pre-write data on a same-row collision.
module memory_1r1w_resp #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUMADDR    = 64,
  parameter int unsigned BITADDR    = 6,
  parameter int unsigned SRAM_DELAY = 2,
  parameter int unsigned RSTINIT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               write,
  input  logic [BITADDR-1:0] wr_adr,
  input  logic [WIDTH-1:0]   bw,
  input  logic [WIDTH-1:0]   din,
  input  logic               read,
  input  logic [BITADDR-1:0] rd_adr,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_dout
);

  localparam logic [BITADDR:0]   NumAddr = (BITADDR + 1)'(NUMADDR);
  localparam logic [BITADDR-1:0] LastRow = BITADDR'(NUMADDR - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e             state_q;
  logic [BITADDR-1:0] init_cnt_q;
  logic               ready_q;

  logic               wr_ok;
  logic               rd_ok;
  logic               init_wr;
  logic [WIDTH-1:0]   rd_data;

  // Sized to the full address space so indices need no truncation; rows at or
  // beyond NUMADDR are never written and never read back.
  logic [WIDTH-1:0]   mem [2**BITADDR];

  logic [SRAM_DELAY-1:0] vld_q;
  logic [WIDTH-1:0]      data_q [SRAM_DELAY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (RSTINIT == 0 || init_cnt_q == LastRow) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StReady: begin
          state_q <= StReady;
        end
        default: begin
          state_q <= StInit;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign init_wr = (state_q == StInit) && (RSTINIT != 0);
  assign wr_ok   = ready_q && write && ({1'b0, wr_adr} < NumAddr);
  assign rd_ok   = ready_q && read;

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[wr_adr] <= (mem[wr_adr] & ~bw) | (din & bw);
    end
  end

  // Array read happens before the write edge lands, so collisions see old data.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_adr} < NumAddr) begin
      rd_data = mem[rd_adr];
    end
  end

  // Data stages only load behind a valid bit, so rd_dout holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < SRAM_DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_ok;
      if (rd_ok) begin
        data_q[0] <= rd_data;
      end
      for (int i = 1; i < SRAM_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign rd_vld  = vld_q[SRAM_DELAY-1];
  assign rd_dout = data_q[SRAM_DELAY-1];

endmodule
